// File: rtl/buff_uart_host_if.sv
// Signal bundle between buff_uart_host and its neighbours: the local byte stream
// and the buffered UART peripheral's address/enable/data register bus.
interface buff_uart_host_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
);

  // Local producer/consumer side
  logic                  in_valid;
  logic [WIDTH-1:0]      in_data;
  logic                  in_ready;
  logic                  rd_req;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;

  // Peripheral register bus
  logic [ADDR_WIDTH-1:0] active_address;
  logic                  read_enable;
  logic                  write_enable;
  logic [WIDTH-1:0]      bus_data_out;
  logic [WIDTH-1:0]      bus_data_in;

  modport master (
    input  in_valid, in_data, rd_req, bus_data_in,
    output in_ready, out_valid, out_data,
           active_address, read_enable, write_enable, bus_data_out
  );

  modport slave (
    output in_valid, in_data, rd_req, bus_data_in,
    input  in_ready, out_valid, out_data,
           active_address, read_enable, write_enable, bus_data_out
  );

endinterface

// File: rtl/buff_uart_host.sv
// Bus initiator for the buffered UART: queues local bytes and writes them to the TX
// register one frame apart, and performs RX-register reads on request.
module buff_uart_host #(
  parameter int WIDTH       = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int TX_ADDR     = 4,
  parameter int RX_ADDR     = 3,
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int GUARD_TICKS = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clock,
  input  logic                reset,
  buff_uart_host_if.master    bus,
  output logic                busy
);

  localparam int TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int FRAME_TICKS   = (WIDTH + 2) * TICKS_PER_BIT + GUARD_TICKS;
  localparam int CNT_W         = $clog2(FRAME_TICKS) + 1;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int LVL_W         = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_CMD,
    S_TX_WAIT,
    S_RX_CMD,
    S_RX_SAMPLE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_count;
  logic [LVL_W-1:0]      w_count_next;
  logic                  r_in_ready;
  logic                  w_push;
  logic                  w_pop;

  logic                  r_rd_pending;
  logic [CNT_W-1:0]      r_frame_cnt;

  logic [WIDTH-1:0]      r_bus_data_out;
  logic [WIDTH-1:0]      r_out_data;
  logic                  r_out_valid;

  logic [ADDR_WIDTH-1:0] w_address;
  logic                  w_read_enable;
  logic                  w_write_enable;

  // ---------------------------------------------------------------------------
  // TX byte FIFO
  // ---------------------------------------------------------------------------
  assign w_push = bus.in_valid && r_in_ready;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + LVL_W'(1);
      2'b01:   w_count_next = r_count - LVL_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are meaningful, which keeps the array mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_in_ready     <= 1'b1;
      r_bus_data_out <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr       <= r_rd_ptr + PTR_W'(1);
        r_bus_data_out <= r_mem[r_rd_ptr];
      end
      r_count    <= w_count_next;
      // Registered from the updated level so in_ready always equals count < depth
      r_in_ready <= (w_count_next < LVL_W'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Pending read request and frame pacing counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
    end else if ((r_state == S_IDLE) && r_rd_pending) begin
      r_rd_pending <= 1'b0;
    end else if (bus.rd_req) begin
      r_rd_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_state == S_TX_CMD) begin
      r_frame_cnt <= CNT_W'(FRAME_TICKS - 1);
    end else if ((r_state == S_TX_WAIT) && (r_frame_cnt != '0)) begin
      r_frame_cnt <= r_frame_cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_address      = '0;
    w_read_enable  = 1'b0;
    w_write_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending read outranks queued transmit bytes
        if (r_rd_pending) begin
          w_state_next = S_RX_CMD;
        end else if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = S_TX_CMD;
        end
      end
      S_TX_CMD: begin
        w_address     = ADDR_WIDTH'(TX_ADDR);
        w_read_enable = 1'b1;
        w_state_next  = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (r_frame_cnt == '0) begin
          w_state_next = S_IDLE;
        end
      end
      S_RX_CMD: begin
        w_address      = ADDR_WIDTH'(RX_ADDR);
        w_write_enable = 1'b1;
        w_state_next   = S_RX_SAMPLE;
      end
      S_RX_SAMPLE: begin
        w_address      = ADDR_WIDTH'(RX_ADDR);
        w_write_enable = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX capture and one-cycle result strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= (r_state == S_RX_SAMPLE);
      if (r_state == S_RX_SAMPLE) begin
        r_out_data <= bus.bus_data_in;
      end
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_data       = r_out_data;
  assign bus.active_address = w_address;
  assign bus.read_enable    = w_read_enable;
  assign bus.write_enable   = w_write_enable;
  assign bus.bus_data_out   = r_bus_data_out;
  assign busy               = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_buff_uart_host.sv
// Directed bench for buff_uart_host with a 102-cycle frame (1000 Hz clock, 100 baud,
// 2 guard ticks) and a peripheral model answering RX-register reads.
module tb_buff_uart_host;

  localparam int TX_GAP = 104;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;

  buff_uart_host_if #(.WIDTH(8), .ADDR_WIDTH(8)) bus_if ();

  buff_uart_host #(
    .WIDTH      (8),
    .ADDR_WIDTH (8),
    .TX_ADDR    (4),
    .RX_ADDR    (3),
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .GUARD_TICKS(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Peripheral model: drives the RX byte while the RX register is being read
  logic [7:0] rx_byte = 8'h0A;
  always_comb begin
    bus_if.bus_data_in = 8'h00;
    if (bus_if.write_enable && (bus_if.active_address == 8'd3)) bus_if.bus_data_in = rx_byte;
  end

  // Bus monitor: logs TX writes, RX results and protocol violations
  int         cyc = 0;
  logic [7:0] tx_q[$];
  int         tx_t[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         wr_cnt = 0;
  int         viol = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus_if.read_enable) begin
        tx_q.push_back(bus_if.bus_data_out);
        tx_t.push_back(cyc);
      end
      if (bus_if.write_enable) wr_cnt = wr_cnt + 1;
      if (bus_if.out_valid) begin
        rx_q.push_back(bus_if.out_data);
        rx_t.push_back(cyc);
      end
      if (bus_if.read_enable && bus_if.write_enable) viol = viol + 1;
      if ((bus_if.active_address != 8'd0) && !bus_if.read_enable && !bus_if.write_enable)
        viol = viol + 1;
    end
  end

  function automatic logic [28:0] out_vec();
    return {bus_if.in_ready, bus_if.out_valid, bus_if.out_data, bus_if.active_address,
            bus_if.read_enable, bus_if.write_enable, bus_if.bus_data_out, busy};
  endfunction

  localparam logic [28:0] RESET_VEC = {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    tick();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    bus_if.rd_req   = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, bus_if.in_ready, bus_if.read_enable, bus_if.write_enable} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_release_idle: busy/ready/re/we=%b required 0100",
               {busy, bus_if.in_ready, bus_if.read_enable, bus_if.write_enable});
    end
  endtask

  task automatic test_single_tx();
    int base;
    int n;
    base = tx_q.size();
    push_byte(8'h0A);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_after_push: busy=%b required 1", busy);
    end
    tick();
    checks++;
    if ({bus_if.active_address, bus_if.read_enable, bus_if.write_enable, bus_if.bus_data_out}
        !== {8'd4, 1'b1, 1'b0, 8'h0A}) begin
      errors++;
      $display("FAIL single_tx_cmd: addr=%h re=%b we=%b data=%h required addr=04 re=1 we=0 data=0a",
               bus_if.active_address, bus_if.read_enable, bus_if.write_enable, bus_if.bus_data_out);
    end
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 103) begin
      errors++;
      $display("FAIL single_busy_duration: busy fell %0d cycles after TX_CMD, required 103", n);
    end
    checks++;
    if (tx_q.size() - base !== 1) begin
      errors++;
      $display("FAIL single_tx_count: %0d writes, required 1", tx_q.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    int   base;
    logic ready_ok;
    base     = tx_q.size();
    ready_ok = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'h0A;
    if (bus_if.in_ready !== 1'b1) ready_ok = 1'b0;
    tick();
    bus_if.in_data = 8'h3E;
    if (bus_if.in_ready !== 1'b1) ready_ok = 1'b0;
    tick();
    bus_if.in_valid = 1'b0;
    if (bus_if.in_ready !== 1'b1) ready_ok = 1'b0;
    checks++;
    if (ready_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready: in_ready dropped (seen %b), required to stay 1", ready_ok);
    end
    wait_idle("b2b", 400);
    checks++;
    if (tx_q.size() - base !== 2) begin
      errors++;
      $display("FAIL b2b_tx_count: %0d writes, required 2", tx_q.size() - base);
    end else begin
      checks++;
      if ({tx_q[base], tx_q[base+1]} !== {8'h0A, 8'h3E}) begin
        errors++;
        $display("FAIL b2b_order: got %h %h required 0a 3e", tx_q[base], tx_q[base+1]);
      end
      checks++;
      if (tx_t[base+1] - tx_t[base] !== TX_GAP) begin
        errors++;
        $display("FAIL b2b_spacing: %0d cycles, required %0d", tx_t[base+1] - tx_t[base], TX_GAP);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] data[6];
    logic [5:0] ready_seen;
    logic [7:0] expect_q[5];
    int         base;
    data     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    expect_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    base     = tx_q.size();
    for (int i = 0; i < 6; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = data[i];
      ready_seen[i]   = bus_if.in_ready;
      tick();
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (ready_seen !== 6'b011111) begin
      errors++;
      $display("FAIL full_in_ready_trace: got %b (push6..push1) required 011111", ready_seen);
    end
    wait_idle("full", 700);
    checks++;
    if (tx_q.size() - base !== 5) begin
      errors++;
      $display("FAIL full_tx_count: %0d writes, required 5", tx_q.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (tx_q[base+i] !== expect_q[i]) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h required %h", i, tx_q[base+i], expect_q[i]);
        end
      end
    end
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_recovered: in_ready=%b required 1", bus_if.in_ready);
    end
  endtask

  task automatic test_rx_read();
    int w0;
    logic [9:0] exp_v;
    w0      = wr_cnt;
    rx_byte = 8'h0A;
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    // k counts cycles after the request: k=2,3 read the bus, k=4 strobes the result
    for (int k = 1; k <= 5; k++) begin
      exp_v = {(k == 2 || k == 3), ((k == 2 || k == 3) ? 8'd3 : 8'd0), (k == 4)};
      checks++;
      if ({bus_if.write_enable, bus_if.active_address, bus_if.out_valid} !== exp_v) begin
        errors++;
        $display("FAIL rx_cycle_%0d: we/addr/ov=%b required %b", k,
                 {bus_if.write_enable, bus_if.active_address, bus_if.out_valid}, exp_v);
      end
      if (k == 4) begin
        checks++;
        if (bus_if.out_data !== 8'h0A) begin
          errors++;
          $display("FAIL rx_out_data: got %h required 0a", bus_if.out_data);
        end
      end
      tick();
    end
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL rx_we_cycles: %0d cycles, required 2", wr_cnt - w0);
    end
  endtask

  task automatic test_rx_merge();
    int tb0;
    int rb0;
    int w0;
    tb0     = tx_q.size();
    rb0     = rx_q.size();
    w0      = wr_cnt;
    rx_byte = 8'h5C;
    push_byte(8'h71);
    push_byte(8'h72);
    repeat (10) tick();
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    repeat (5) tick();
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    wait_idle("merge", 500);
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL merge_we_cycles: %0d cycles, required 2 (one read)", wr_cnt - w0);
    end
    checks++;
    if ((rx_q.size() - rb0 !== 1) || (tx_q.size() - tb0 !== 2)) begin
      errors++;
      $display("FAIL merge_counts: rx=%0d tx=%0d required rx=1 tx=2",
               rx_q.size() - rb0, tx_q.size() - tb0);
    end else begin
      checks++;
      if (rx_q[rb0] !== 8'h5C) begin
        errors++;
        $display("FAIL merge_rx_data: got %h required 5c", rx_q[rb0]);
      end
      checks++;
      if (rx_t[rb0] - tx_t[tb0] !== 106) begin
        errors++;
        $display("FAIL merge_rx_timing: strobe %0d cycles after first TX_CMD, required 106",
                 rx_t[rb0] - tx_t[tb0]);
      end
      checks++;
      if ((tx_q[tb0+1] !== 8'h72) || (tx_t[tb0+1] - tx_t[tb0] !== 107)) begin
        errors++;
        $display("FAIL merge_second_tx: data=%h gap=%0d required data=72 gap=107",
                 tx_q[tb0+1], tx_t[tb0+1] - tx_t[tb0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int tb0;
    int rb0;
    int w0;
    int busy_seen;
    push_byte(8'h81);
    push_byte(8'h82);
    push_byte(8'h83);
    repeat (10) tick();
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h required %h", out_vec(), RESET_VEC);
    end
    tick();
    tick();
    reset = 1'b0;
    tb0 = tx_q.size();
    rb0 = rx_q.size();
    w0  = wr_cnt;
    busy_seen = 0;
    repeat (300) begin
      tick();
      if (busy) busy_seen++;
    end
    checks++;
    if ((tx_q.size() != tb0) || (rx_q.size() != rb0) || (wr_cnt != w0)) begin
      errors++;
      $display("FAIL mid_reset_no_activity: tx=%0d rx=%0d we=%0d required 0 0 0",
               tx_q.size() - tb0, rx_q.size() - rb0, wr_cnt - w0);
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_busy: busy high %0d cycles, required 0", busy_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_fifo_full();
    test_rx_read();
    test_rx_merge();
    test_reset_mid();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL bus_protocol: %0d violations, required 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
